// File: rtl/int_alu_pkg.sv
// Shared definitions for the integer ALU arbiters: FSM encoding and operand slicing.
package int_alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StWait = ST_WAIT,
    StResp = ST_RESP
  } arb_state_e;

  // Low bit of requester idx's slice in a flat packed operand bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_o
);

  always_comb begin : p_search
    int unsigned idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/int_adder_arb.sv
// Round-robin sequencer sharing one registered integer adder between NUM_REQ requesters.
module int_adder_arb
  import int_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADD_LAT    = 1,
  parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_sum,
  output logic                          resp_cout,
  output logic [ID_W-1:0]               resp_id,
  output logic                          add_en,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  output logic                          add_cin,
  input  logic [DATA_WIDTH-1:0]         add_sum,
  input  logic                          add_cout,
  output logic                          busy
);

  localparam int unsigned CntW = 2;
  localparam logic [CntW-1:0] CntInit = CntW'((ADD_LAT > 1) ? ADD_LAT - 2 : 0);

  arb_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    ptr_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    ptr_next;
  logic               any_req;
  logic               idle;
  logic               issue;

  rr_arb #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr_arb (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .any_o      (any_req)
  );

  assign ptr_next = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q <= grant_idx;
            ptr_q   <= ptr_next;
            if (ADD_LAT == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) state_q <= StResp;
          else             cnt_q   <= cnt_q - CntW'(1);
        end
        StResp: begin
          if (resp_ready[owner_q]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gate with rst_n so nothing is granted while reset is held.
  assign idle  = (state_q == StIdle) & rst_n;
  assign issue = idle & any_req;

  assign req_ready = idle ? grant : '0;
  assign add_en    = issue;
  assign add_a     = issue ? req_a[slice_lo(32'(grant_idx), DATA_WIDTH) +: DATA_WIDTH] : '0;
  assign add_b     = issue ? req_b[slice_lo(32'(grant_idx), DATA_WIDTH) +: DATA_WIDTH] : '0;
  assign add_cin   = issue & req_cin[grant_idx];

  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) resp_valid[owner_q] = 1'b1;
  end

  assign resp_id   = owner_q;
  assign resp_sum  = add_sum;
  assign resp_cout = add_cout;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_int_adder_arb.sv
// Scoreboard bench for int_adder_arb with a behavioural adder and arbitration reference.
module tb_int_adder_arb;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Main instance, ADD_LAT=1
  logic [N-1:0]   req_valid, req_ready, req_cin, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   resp_sum, add_a, add_b;
  logic [W-1:0]   add_sum = '0;
  logic           resp_cout, add_en, add_cin, busy;
  logic           add_cout = 1'b0;
  logic [1:0]     resp_id;

  // Second instance, ADD_LAT=3
  logic [N-1:0]   l3_req_valid, l3_req_ready, l3_req_cin, l3_resp_valid;
  logic [N-1:0]   l3_resp_ready = '1;
  logic [N*W-1:0] l3_req_a, l3_req_b;
  logic [W-1:0]   l3_resp_sum, l3_add_a, l3_add_b;
  logic [W-1:0]   l3_add_sum = '0;
  logic           l3_resp_cout, l3_add_en, l3_add_cin, l3_busy;
  logic           l3_add_cout = 1'b0;
  logic [1:0]     l3_resp_id;

  int_adder_arb #(.DATA_WIDTH(W), .NUM_REQ(N), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
  );

  int_adder_arb #(.DATA_WIDTH(W), .NUM_REQ(N), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_a(l3_req_a), .req_b(l3_req_b), .req_cin(l3_req_cin), .resp_valid(l3_resp_valid),
    .resp_ready(l3_resp_ready), .resp_sum(l3_resp_sum), .resp_cout(l3_resp_cout),
    .resp_id(l3_resp_id), .add_en(l3_add_en), .add_a(l3_add_a), .add_b(l3_add_b),
    .add_cin(l3_add_cin), .add_sum(l3_add_sum), .add_cout(l3_add_cout), .busy(l3_busy)
  );

  // Behavioural registered adders
  always @(posedge clk)
    if (add_en) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
  always @(posedge clk)
    if (l3_add_en) {l3_add_cout, l3_add_sum} <= {1'b0, l3_add_a} + {1'b0, l3_add_b} + 33'(l3_add_cin);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [W-1:0] sum;
    logic       cout;
    int         acc;
    bit         seen;
  } exp_t;

  exp_t q[$];
  int   ptr_m  = 0;
  bit   m_busy = 0;

  // Monitor: checks issue side against the reference and pops results as they are accepted.
  initial begin : mon
    int g;
    bit done;
    logic [W:0] full;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_busy = 0;
        ptr_m  = 0;
      end else begin
        done = 0;
        if (q.size() != 0) begin
          if (resp_valid != '0) begin
            if (!q[0].seen) begin
              chk("resp_latency", cyc - q[0].acc, LAT);
              q[0].seen = 1;
            end
            chk("resp_valid", resp_valid, 1 << q[0].id);
            chk("resp_id", resp_id, q[0].id);
            chk("resp_sum", resp_sum, q[0].sum);
            chk("resp_cout", resp_cout, q[0].cout);
            if (resp_ready[q[0].id]) begin
              done = 1;
              void'(q.pop_front());
            end
          end else if (cyc - q[0].acc >= LAT) begin
            chk("resp_missing", resp_valid, 1 << q[0].id);
          end
        end else if (resp_valid != '0) begin
          chk("resp_spurious", resp_valid, 0);
        end
        chk("busy", busy, m_busy);
        if (m_busy) begin
          chk("no_issue_busy", {req_ready, add_en, add_cin, add_a, add_b}, 0);
        end else if (req_valid == '0) begin
          chk("no_issue_idle", {req_ready, add_en, add_cin, add_a, add_b}, 0);
        end else begin
          g = -1;
          for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
          chk("grant", req_ready, 1 << g);
          chk("add_en", add_en, 1);
          chk("add_ops", {add_a, add_b, add_cin}, {req_a[g*W +: W], req_b[g*W +: W], req_cin[g]});
          full = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + 33'(req_cin[g]);
          e.id = g; e.sum = full[W-1:0]; e.cout = full[W]; e.acc = cyc; e.seen = 0;
          q.push_back(e);
          ptr_m  = (g + 1) % N;
          m_busy = 1;
        end
        if (done) m_busy = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
    req_valid[i]    = 1'b1;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    bit ok = 0;
    set_req(i, a, b, c);
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    chk("issue_granted", ok, 1);
  endtask

  task automatic drain();
    logic [N-1:0] acc;
    for (int k = 0; k < 60 && req_valid != '0; k++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid &= ~acc;
    end
    chk("drain_done", req_valid, 0);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy && q.size() == 0 && req_valid == '0) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    int last, ngr, g;
    bit seq_ok, hold_ok;
    logic [N-1:0] acc;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; resp_ready = '0;
    l3_req_valid = '0; l3_req_a = '0; l3_req_b = '0; l3_req_cin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {req_ready, resp_valid, add_en, add_cin, resp_id, busy}, 0);
    chk("rst_add_ops", {add_a, add_b}, 0);
    chk("rst_l3_outs", {l3_req_ready, l3_resp_valid, l3_add_en, l3_resp_id, l3_busy}, 0);
    rst_n = 1'b1;
    resp_ready = '1;

    // Single request from requester 2
    @(posedge clk); #1;
    set_req(2, 32'h5, 32'h3, 1'b1);
    #1;
    chk("t1_req_ready", req_ready, 4'b0100);
    chk("t1_add_en", add_en, 1);
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    chk("t1_resp_valid", resp_valid, 4'b0100);
    chk("t1_resp_id", resp_id, 2);
    chk("t1_sum", resp_sum, 32'h9);
    chk("t1_cout", resp_cout, 0);
    wait_idle();

    // Carry out on wrap
    issue(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    #1;
    chk("t2_sum", resp_sum, 0);
    chk("t2_cout", resp_cout, 1);
    wait_idle();

    // All requesters valid: rotating grants every two cycles
    for (int i = 0; i < N; i++) set_req(i, rnd(), rnd(), 1'($urandom_range(0, 1)));
    last = -1; ngr = 0; seq_ok = 1;
    repeat (16) begin
      #1;
      if (req_ready != '0) begin
        g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        if (last >= 0 && g != (last + 1) % N) seq_ok = 0;
        last = g;
        ngr++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("rr_order", seq_ok, 1);
    chk("rr_grants", ngr, 8);
    wait_idle();

    // Back-pressure on requester 1 while others wait
    resp_ready = 4'b1101;
    issue(1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    set_req(0, 32'h7, 32'h8, 1'b0);
    set_req(3, 32'h1, 32'h2, 1'b0);
    hold_ok = 1;
    repeat (5) begin
      #1;
      if (resp_valid != 4'b0010 || resp_sum != 32'h2345_678A || req_ready != '0 || add_en)
        hold_ok = 0;
      @(posedge clk); #1;
    end
    chk("bp_hold", hold_ok, 1);
    resp_ready = '1;
    drain();
    wait_idle();

    // Randomised traffic with random back-pressure and withdrawn requests
    repeat (400) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, rnd(), rnd(), 1'($urandom_range(0, 1)));
        end
        resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end
    resp_ready = '1;
    drain();
    wait_idle();

    // ADD_LAT=3 instance: single request from requester 1
    l3_req_a[1*W +: W] = 32'd100;
    l3_req_b[1*W +: W] = 32'd23;
    l3_req_cin[1]      = 1'b1;
    l3_req_valid       = 4'b0010;
    #1;
    chk("l3_c0_add_en", l3_add_en, 1);
    chk("l3_c0_ready", l3_req_ready, 4'b0010);
    chk("l3_c0_busy", l3_busy, 0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      l3_req_valid = '0;
      #1;
      chk("l3_busy", l3_busy, 1);
      chk("l3_add_en_off", l3_add_en, 0);
      chk("l3_resp_valid", l3_resp_valid, (c == 3) ? 4'b0010 : 4'b0000);
    end
    chk("l3_sum", l3_resp_sum, 32'd124);
    chk("l3_id", l3_resp_id, 1);
    @(posedge clk); #1;
    chk("l3_idle", l3_busy, 0);

    // Reset mid-operation: main stalled in RESP, l3 in WAIT
    resp_ready = 4'b1011;
    issue(2, 32'd40, 32'd2, 1'b0);
    l3_req_a[2*W +: W] = 32'd9;
    l3_req_b[2*W +: W] = 32'd9;
    l3_req_cin[2]      = 1'b0;
    l3_req_valid       = 4'b0100;
    @(posedge clk); #1;
    l3_req_valid = 4'b1010;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_l3", {l3_req_ready, l3_resp_valid, l3_add_en, l3_add_cin, l3_resp_id, l3_busy}, 0);
    chk("rst_mid_l3_ops", {l3_add_a, l3_add_b}, 0);
    chk("rst_mid_main", {req_ready, resp_valid, add_en, add_cin, resp_id, busy}, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    resp_ready = '1;
    set_req(2, 32'd5, 32'd6, 1'b0);
    set_req(3, 32'd7, 32'd8, 1'b1);
    #1;
    chk("rst_l3_grant_from0", l3_req_ready, 4'b0010);
    chk("rst_main_grant_from0", req_ready, 4'b0100);
    @(posedge clk); #1;
    l3_req_valid = '0;
    drain();
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
